// File: rtl/mem_port_initiator.sv
// mem_port_initiator: in-order load/store initiator for a 1-port synchronous RAM
// with 1-cycle read latency. The LSU side pushes requests into a small FIFO; the head
// is issued to the RAM and load data is returned with its tag over a valid/ready port.
// Only one op awaits capture at a time, so responses leave strictly in request order.
// Optional build macro: MEM_PORT_STORE_ACK_EN -- stores also return a response
// (rsp_wr=1, rdata=0) and obey the same issue rules as loads. Undefined: stores are
// fire-and-forget and o_rsp_wr is tied low.
//
// state  | meaning
// S_IDLE | nothing awaiting capture; FIFO head may issue
// S_BUSY | op issued last cycle; its response is captured at the end of this cycle

module mem_port_initiator #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int TAG_WIDTH     = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_wr,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  input  logic [TAG_WIDTH-1:0]     i_req_tag,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
  output logic [TAG_WIDTH-1:0]     o_rsp_tag,
  output logic                     o_rsp_wr,
  output logic                     o_mem_wen,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic                     r_fifo_wr    [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_wdata [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]     r_fifo_tag   [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wptr, r_rptr;
  logic [PTR_W:0]           r_count;

  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_rdata;
  logic [TAG_WIDTH-1:0]     r_rsp_tag;
  logic [TAG_WIDTH-1:0]     r_op_tag;
`ifdef MEM_PORT_STORE_ACK_EN
  logic                     r_op_wr;
  logic                     r_rsp_wr;
`endif

  logic w_empty, w_full, w_req_ready, w_push;
  logic w_issue, w_track, w_mem_wen;
  logic w_head_wr;
  logic [TAG_WIDTH-1:0] w_head_tag;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  // Ready depends only on occupancy, so a pop in the same cycle never frees a full FIFO.
  assign w_req_ready = !i_reset && !w_full;
  assign w_push      = i_req_valid && w_req_ready;

  assign w_head_wr   = r_fifo_wr[r_rptr];
  assign w_head_tag  = r_fifo_tag[r_rptr];

  assign o_req_ready = w_req_ready;
  assign o_mem_addr  = r_fifo_addr[r_rptr];
  assign o_mem_wdata = r_fifo_wdata[r_rptr];
  assign o_mem_wen   = w_mem_wen;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_tag   = r_rsp_tag;
`ifdef MEM_PORT_STORE_ACK_EN
  assign o_rsp_wr    = r_rsp_wr;
`else
  assign o_rsp_wr    = 1'b0;
`endif

  // Request FIFO storage; written at the tail on every accepted request.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_wr[r_wptr]    <= i_req_wr;
      r_fifo_addr[r_wptr]  <= i_req_addr;
      r_fifo_wdata[r_wptr] <= i_req_wdata;
      r_fifo_tag[r_wptr]   <= i_req_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue decision and next state. A held response blocks anything that would need
  // the response register, which keeps responses in order without a second buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_track     = 1'b0;
    w_mem_wen   = 1'b0;
    if (r_state == S_IDLE && !w_empty && !i_reset) begin
`ifdef MEM_PORT_STORE_ACK_EN
      if (!r_rsp_valid) begin
        w_issue   = 1'b1;
        w_track   = 1'b1;
        w_mem_wen = w_head_wr;
      end
`else
      if (w_head_wr) begin
        w_issue   = 1'b1;
        w_mem_wen = 1'b1;
      end else if (!r_rsp_valid) begin
        w_issue   = 1'b1;
        w_track   = 1'b1;
      end
`endif
    end
    if (r_state == S_BUSY) begin
      w_state_nxt = S_IDLE;
    end else if (w_track) begin
      w_state_nxt = S_BUSY;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Remember the identity of the op awaiting capture.
  always_ff @(posedge i_clk) begin
    if (w_track) begin
      r_op_tag <= w_head_tag;
`ifdef MEM_PORT_STORE_ACK_EN
      r_op_wr  <= w_head_wr;
`endif
    end
  end

  // Response register: capture RAM data one cycle after issue, hold until accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_tag   <= '0;
`ifdef MEM_PORT_STORE_ACK_EN
      r_rsp_wr    <= 1'b0;
`endif
    end else if (r_state == S_BUSY) begin
      r_rsp_valid <= 1'b1;
      r_rsp_tag   <= r_op_tag;
`ifdef MEM_PORT_STORE_ACK_EN
      r_rsp_rdata <= r_op_wr ? '0 : i_mem_rdata;
      r_rsp_wr    <= r_op_wr;
`else
      r_rsp_rdata <= i_mem_rdata;
`endif
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: behavioural 1-port RAM, response/write monitors,
// a table of single transactions plus hand-written multi-cycle sequences.
// Builds for either setting of MEM_PORT_STORE_ACK_EN.

module tb_mem_port_initiator;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_ready, rsp_wr;
  logic [DW-1:0] rsp_rdata;
  logic [TW-1:0] rsp_tag;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_initiator #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TAG_WIDTH(TW), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_tag(req_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_tag(rsp_tag), .o_rsp_wr(rsp_wr),
    .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  typedef struct { logic [TW-1:0] tag; logic [DW-1:0] rdata; logic wr; int cyc; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wrec_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [TW-1:0] tag;
                   logic [DW-1:0] exp_rdata; } vec_t;

  rsp_t  rsp_q[$];
  wrec_t wen_q[$];
  int    cyc_cnt = 0;
  int    wr_hi_cnt = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  bit [DW-1:0]      ram [1<<AW];
  bit [(1<<AW)-1:0] written;

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | {20'h0, a};
  endfunction

  // 1-port RAM: write on wen, otherwise registered read; dataOut held on writes.
  always @(posedge clk) begin
    if (mem_wen) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end else begin
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : fill(mem_addr);
    end
  end

  // Monitor: response handshakes and RAM writes, stamped with the cycle they occur in.
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) rsp_q.push_back('{rsp_tag, rsp_rdata, rsp_wr, cyc_cnt});
    if (mem_wen) wen_q.push_back('{mem_addr, mem_wdata, cyc_cnt});
    if (rsp_wr) wr_hi_cnt <= wr_hi_cnt + 1;
    cyc_cnt <= cyc_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one request starting at this negedge; acc = cycle in which it is accepted.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [TW-1:0] t, output int acc);
    int k;
    k = 0;
    acc = -1;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_tag = t;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("send_accept", req_ready, 1);
    if (req_ready) acc = cyc_cnt;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  vec_t vecs[8];
  int   b, wb, acc, ts, tl, idx, k, unstable;
  logic [TW-1:0] snap_tag;
  logic [DW-1:0] snap_rdata;
  logic [TW-1:0] exp_tags[4];
  logic [DW-1:0] exp_data[4];
  int            exp_n;

  initial begin
    vecs[0] = '{1'b1, 12'h040, 32'h1234_5678, 4'd5,  32'h0};
    vecs[1] = '{1'b0, 12'h040, 32'h0,         4'd6,  32'h1234_5678};
    vecs[2] = '{1'b0, 12'h041, 32'h0,         4'd7,  fill(12'h041)};
    vecs[3] = '{1'b1, 12'h041, 32'hCAFE_F00D, 4'd8,  32'h0};
    vecs[4] = '{1'b0, 12'h041, 32'h0,         4'd9,  32'hCAFE_F00D};
    vecs[5] = '{1'b1, 12'hFFF, 32'hFFFF_FFFF, 4'd15, 32'h0};
    vecs[6] = '{1'b0, 12'hFFF, 32'h0,         4'd0,  32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 12'h000, 32'h0,         4'd1,  fill(12'h000)};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
    rsp_ready = 1'b0;

    // Reset held 3 cycles.
    idle(3);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    // Store then load to the same address, with latency.
    rsp_ready = 1'b1;
    b = rsp_q.size(); wb = wen_q.size();
    send(1'b1, 12'h010, 32'hDEAD_BEEF, 4'd1, ts);
    send(1'b0, 12'h010, 32'h0, 4'd2, tl);
    idle(8);
    chk("sl_wen_count", wen_q.size() - wb, 1);
    if (wen_q.size() > wb) begin
      chk("sl_wen_addr", wen_q[wb].addr, 12'h010);
      chk("sl_wen_data", wen_q[wb].data, 32'hDEAD_BEEF);
      chk("sl_wen_cycle", wen_q[wb].cyc, ts + 1);
    end
`ifdef MEM_PORT_STORE_ACK_EN
    chk("sl_rsp_count", rsp_q.size() - b, 2);
    idx = b + 1;
`else
    chk("sl_rsp_count", rsp_q.size() - b, 1);
    idx = b;
    if (rsp_q.size() > idx) chk("sl_latency", rsp_q[idx].cyc, tl + 3);
`endif
    if (rsp_q.size() > idx) begin
      chk("sl_rsp_tag", rsp_q[idx].tag, 2);
      chk("sl_rsp_rdata", rsp_q[idx].rdata, 32'hDEAD_BEEF);
      chk("sl_rsp_wr", rsp_q[idx].wr, 0);
    end

    // Table of single transactions, each run to completion.
    for (int i = 0; i < 8; i++) begin
      b = rsp_q.size(); wb = wen_q.size();
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].tag, acc);
      idle(6);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_wen_count", i), wen_q.size() - wb, 1);
        if (wen_q.size() > wb) begin
          chk($sformatf("vec%0d_wen_addr", i), wen_q[wb].addr, vecs[i].addr);
          chk($sformatf("vec%0d_wen_data", i), wen_q[wb].data, vecs[i].wdata);
        end
`ifdef MEM_PORT_STORE_ACK_EN
        chk($sformatf("vec%0d_ack_count", i), rsp_q.size() - b, 1);
        if (rsp_q.size() > b) begin
          chk($sformatf("vec%0d_ack_tag", i), rsp_q[b].tag, vecs[i].tag);
          chk($sformatf("vec%0d_ack_wr", i), rsp_q[b].wr, 1);
          chk($sformatf("vec%0d_ack_rdata", i), rsp_q[b].rdata, 0);
        end
`else
        chk($sformatf("vec%0d_no_rsp", i), rsp_q.size() - b, 0);
`endif
      end else begin
        chk($sformatf("vec%0d_rsp_count", i), rsp_q.size() - b, 1);
        chk($sformatf("vec%0d_no_wen", i), wen_q.size() - wb, 0);
        if (rsp_q.size() > b) begin
          chk($sformatf("vec%0d_tag", i), rsp_q[b].tag, vecs[i].tag);
          chk($sformatf("vec%0d_rdata", i), rsp_q[b].rdata, vecs[i].exp_rdata);
          chk($sformatf("vec%0d_wr", i), rsp_q[b].wr, 0);
          chk($sformatf("vec%0d_latency", i), rsp_q[b].cyc, acc + 3);
        end
      end
    end

    // Fill: 8 back-to-back loads with the consumer stalled; 1 in rsp + 4 queued.
    rsp_ready = 1'b0;
    b = rsp_q.size();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_tag = TW'(idx); req_addr = 12'h100 + AW'(idx);
      if (req_ready) idx++;
      @(negedge clk);
    end
    chk("fill_accepted", idx, 5);
    chk("fill_req_ready", req_ready, 0);
    chk("fill_rsp_valid", rsp_valid, 1);
    chk("fill_rsp_tag", rsp_tag, 0);
    chk("fill_no_handshake", rsp_q.size() - b, 0);
    rsp_ready = 1'b1;
    k = 0;
    while (rsp_q.size() - b < 8 && k < 80) begin
      if (idx < 8) begin
        req_valid = 1'b1; req_tag = TW'(idx); req_addr = 12'h100 + AW'(idx);
        if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    chk("drain_accepted", idx, 8);
    chk("drain_rsp_count", rsp_q.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      if (rsp_q.size() > b + i) begin
        chk($sformatf("drain%0d_tag", i), rsp_q[b+i].tag, i);
        chk($sformatf("drain%0d_rdata", i), rsp_q[b+i].rdata, fill(12'h100 + AW'(i)));
      end
    end
    idle(2);

    // Backpressure: held response stays stable; queued stores keep issuing.
    rsp_ready = 1'b0;
    b = rsp_q.size(); wb = wen_q.size();
    send(1'b0, 12'h200, 32'h0,  4'd9,  acc);
    send(1'b1, 12'h300, 32'h11, 4'd10, acc);
    send(1'b1, 12'h301, 32'h22, 4'd11, acc);
    send(1'b0, 12'h202, 32'h0,  4'd12, acc);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    snap_tag = rsp_tag; snap_rdata = rsp_rdata;
    chk("bp_first_tag", snap_tag, 9);
    chk("bp_first_rdata", snap_rdata, fill(12'h200));
    unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_tag !== snap_tag || rsp_rdata !== snap_rdata) unstable++;
    end
    chk("bp_stable_cycles", unstable, 0);
    chk("bp_no_handshake", rsp_q.size() - b, 0);
`ifndef MEM_PORT_STORE_ACK_EN
    chk("bp_store_count", wen_q.size() - wb, 2);
    if (wen_q.size() > wb + 1) begin
      chk("bp_store0_addr", wen_q[wb].addr, 12'h300);
      chk("bp_store1_addr", wen_q[wb+1].addr, 12'h301);
      chk("bp_store1_data", wen_q[wb+1].data, 32'h22);
    end
    exp_n = 2;
    exp_tags[0] = 4'd9;  exp_data[0] = fill(12'h200);
    exp_tags[1] = 4'd12; exp_data[1] = fill(12'h202);
`else
    exp_n = 4;
    exp_tags[0] = 4'd9;  exp_data[0] = fill(12'h200);
    exp_tags[1] = 4'd10; exp_data[1] = 32'h0;
    exp_tags[2] = 4'd11; exp_data[2] = 32'h0;
    exp_tags[3] = 4'd12; exp_data[3] = fill(12'h202);
`endif
    rsp_ready = 1'b1;
    idle(15);
    chk("bp_rsp_count", rsp_q.size() - b, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (rsp_q.size() > b + i) begin
        chk($sformatf("bp%0d_tag", i), rsp_q[b+i].tag, exp_tags[i]);
        chk($sformatf("bp%0d_rdata", i), rsp_q[b+i].rdata, exp_data[i]);
      end
    end

    // Reset with one load in flight and three queued behind it.
    rsp_ready = 1'b0;
    send(1'b0, 12'h210, 32'h0, 4'hA, acc);
    for (int i = 1; i <= 4; i++) send(1'b0, 12'h210 + AW'(i), 32'h0, TW'(i), acc);
    chk("mr_full", req_ready, 0);
    chk("mr_held_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("mr_in_flight_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    idle(2);
    chk("mr_rst_req_ready", req_ready, 0);
    chk("mr_rst_mem_wen", mem_wen, 0);
    rst = 1'b0;
    b = rsp_q.size();
    rsp_ready = 1'b1;
    idle(10);
    chk("mr_no_rsp_after", rsp_q.size() - b, 0);
    chk("mr_rsp_valid_low", rsp_valid, 0);
    chk("mr_req_ready", req_ready, 1);
    send(1'b0, 12'h220, 32'h0, 4'd7, acc);
    idle(6);
    chk("mr_next_count", rsp_q.size() - b, 1);
    if (rsp_q.size() > b) begin
      chk("mr_next_tag", rsp_q[b].tag, 7);
      chk("mr_next_rdata", rsp_q[b].rdata, fill(12'h220));
      chk("mr_next_latency", rsp_q[b].cyc, acc + 3);
    end

    // Store to 0x020: acknowledged only when the ack build option is on.
    b = rsp_q.size(); wb = wen_q.size();
    send(1'b1, 12'h020, 32'h5, 4'd3, acc);
    idle(6);
    chk("st_wen_count", wen_q.size() - wb, 1);
    if (wen_q.size() > wb) chk("st_wen_addr", wen_q[wb].addr, 12'h020);
`ifdef MEM_PORT_STORE_ACK_EN
    chk("st_ack_count", rsp_q.size() - b, 1);
    if (rsp_q.size() > b) begin
      chk("st_ack_wr", rsp_q[b].wr, 1);
      chk("st_ack_rdata", rsp_q[b].rdata, 0);
      chk("st_ack_tag", rsp_q[b].tag, 3);
    end
`else
    chk("st_no_rsp", rsp_q.size() - b, 0);
    chk("rsp_wr_never_high", wr_hi_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
